// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and FSM encoding for the UART transmit arbiter.
// Pure declarations: no latency, no flow control.
package uart_tx_arbiter_pkg;

  localparam int NREQ_DEF         = 4;
  localparam int CLKS_PER_BIT_DEF = 16;
  localparam int BYTE_W           = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter signals of the UART arbiter; the arbiter sits on the master modport.
// Wires only: no latency, handshakes are level req / one-cycle ack and tx_busy.
interface uart_tx_arbiter_if
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
);

  logic [NREQ-1:0]        req;
  logic [BYTE_W*NREQ-1:0] req_data;
  logic [NREQ-1:0]        ack;
  logic                   tx_wr_en;
  logic [BYTE_W-1:0]      tx_data;
  logic                   tx_enb;
  logic                   tx_busy;
  logic [2:0]             grant_id;
  logic                   active;

  modport master (
    input  req, req_data, tx_busy,
    output ack, tx_wr_en, tx_data, tx_enb, grant_id, active
  );

  modport slave (
    output req, req_data, tx_busy,
    input  ack, tx_wr_en, tx_data, tx_enb, grant_id, active
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running bit-rate divider: tx_enb pulses once every CLKS_PER_BIT cycles.
// Pulse decoded from the counter register; never stalls, takes no backpressure.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  output logic tx_enb
);

  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tx_enb = (cnt == LAST);

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding N byte requesters into one UART transmitter.
// ack 1 cycle after req sampled in IDLE, tx_wr_en 1 cycle after ack; new grants wait for idle FSM and tx_busy low.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int NREQ         = NREQ_DEF,
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input logic                clk,
  input logic                rst_n,
  uart_tx_arbiter_if.master  bus
);

  state_t            state, state_nxt;
  logic              armed;
  logic [2:0]        grant_q;
  logic [BYTE_W-1:0] tx_data_q;
  logic [NREQ-1:0]   ack_q, ack_nxt;
  logic              wr_q, wr_nxt;
  logic              active_q;
  logic              win_found;
  logic [2:0]        win_idx;
  logic              can_grant;

  uart_baud_tick #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .tx_enb (bus.tx_enb)
  );

  // Search starts one past the last grant so a held request cannot starve the others.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!win_found && bus.req[(int'(grant_q) + i) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = 3'((int'(grant_q) + i) % NREQ);
      end
    end
  end

  // armed holds off grants for the first edge after reset release.
  assign can_grant = (state == ST_IDLE) && armed && !bus.tx_busy && win_found;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (can_grant)    state_nxt = ST_LAUNCH;
      ST_LAUNCH:                      state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: if (bus.tx_busy)  state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (!bus.tx_busy) state_nxt = ST_IDLE;
      default:                        state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_nxt = '0;
    wr_nxt  = 1'b0;
    if (can_grant) begin
      ack_nxt = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
    end
    if (state == ST_LAUNCH) begin
      wr_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed     <= 1'b0;
      grant_q   <= 3'(NREQ - 1);
      tx_data_q <= '0;
      ack_q     <= '0;
      wr_q      <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      armed    <= 1'b1;
      ack_q    <= ack_nxt;
      wr_q     <= wr_nxt;
      active_q <= (state_nxt != ST_IDLE);
      if (can_grant) begin
        grant_q   <= win_idx;
        tx_data_q <= bus.req_data[BYTE_W*win_idx +: BYTE_W];
      end
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_wr_en = wr_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.grant_id = grant_q;
  assign bus.active   = active_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: vector table of single grants, hand sequences for reset, rotation and busy hold-off.
// Expected bytes are queued when requests are driven and popped whenever tx_wr_en fires.
module tb_uart_tx_arbiter;

  localparam int NREQ = 4;
  localparam int CPB  = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ         (NREQ),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for busy_len cycles after each write strobe.
  int   model_cnt;
  int   busy_len   = 40;
  logic busy_force = 1'b0;
  assign bus.tx_busy = (model_cnt != 0) || busy_force;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)               model_cnt <= 0;
    else if (bus.tx_wr_en)    model_cnt <= busy_len;
    else if (model_cnt != 0)  model_cnt <= model_cnt - 1;
  end

  int              ack_cnt[NREQ] = '{default: 0};
  int              ack_total = 0;
  int              wr_total  = 0;
  logic [NREQ-1:0] prev_ack  = '0;
  int              enb_gap   = 0;
  logic            enb_seen  = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ack = '0;
      enb_seen = 1'b0;
      enb_gap  = 0;
    end else begin
      if (bus.ack != '0) begin
        check("ack_onehot", 32'($onehot(bus.ack)), 32'd1);
        ack_total++;
        for (int i = 0; i < NREQ; i++) if (bus.ack[i]) ack_cnt[i]++;
      end
      if (bus.tx_wr_en || prev_ack != '0)
        check("wr_follows_ack", 32'(bus.tx_wr_en), 32'(prev_ack != '0));
      if (bus.tx_wr_en) begin
        wr_total++;
        if (sb_q.size() == 0) check("sb_write_expected", 32'(sb_q.size()), 32'd1);
        else                  check("sb_tx_data", 32'(bus.tx_data), 32'(sb_q.pop_front()));
      end
      enb_gap++;
      if (bus.tx_enb) begin
        if (enb_seen) check("enb_period", 32'(enb_gap), 32'(CPB));
        enb_seen = 1'b1;
        enb_gap  = 0;
      end
      prev_ack = bus.ack;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int w = 0;
    while ((bus.active || bus.tx_busy) && w < 600) begin
      tick();
      w++;
    end
    check(name, 32'(w < 600), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ack"},      32'(bus.ack),      32'd0);
    check({tag, "_tx_wr_en"}, 32'(bus.tx_wr_en), 32'd0);
    check({tag, "_tx_enb"},   32'(bus.tx_enb),   32'd0);
    check({tag, "_active"},   32'(bus.active),   32'd0);
    check({tag, "_tx_data"},  32'(bus.tx_data),  32'd0);
    check({tag, "_grant_id"}, 32'(bus.grant_id), 32'(NREQ - 1));
  endtask

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  exp_ack;
    logic [2:0]  exp_gid;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n_ack;
    int hi_cnt;
    int base[NREQ];
    int c3;

    // Grant sequence below assumes it starts straight after reset (last grant = 3).
    vecs[0] = '{4'b0100, 32'h00A50000, 4'b0100, 3'd2, 8'hA5};
    vecs[1] = '{4'b0011, 32'h00002B1A, 4'b0001, 3'd0, 8'h1A};
    vecs[2] = '{4'b1001, 32'h3C00004D, 4'b1000, 3'd3, 8'h3C};
    vecs[3] = '{4'b1001, 32'h5E00006F, 4'b0001, 3'd0, 8'h6F};
    vecs[4] = '{4'b1110, 32'h77665544, 4'b0010, 3'd1, 8'h55};
    vecs[5] = '{4'b1000, 32'h88000000, 4'b1000, 3'd3, 8'h88};
    vecs[6] = '{4'b0001, 32'h00000099, 4'b0001, 3'd0, 8'h99};
    vecs[7] = '{4'b0110, 32'h00CCBB00, 4'b0010, 3'd1, 8'hBB};

    bus.req      = '0;
    bus.req_data = '0;
    tick();
    check_reset_outputs("por");
    rst_n = 1'b1;

    // Idle window: divider runs, nothing else moves.
    hi_cnt = 0;
    n_ack  = 0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (bus.active) hi_cnt++;
      if (bus.tx_enb) n_ack++;
    end
    check("idle_enb_pulses", 32'(n_ack), 32'd3);
    check("idle_active_cycles", 32'(hi_cnt), 32'd0);
    check("idle_ack_total", 32'(ack_total), 32'd0);
    check("idle_wr_total", 32'(wr_total), 32'd0);

    for (int v = 0; v < 8; v++) begin
      busy_len = (v == 0) ? 40 : 4;
      wait_idle("vec_pre_idle");
      bus.req      = vecs[v].req;
      bus.req_data = vecs[v].data;
      sb_q.push_back(vecs[v].exp_byte);
      tick();
      check("vec_ack", 32'(bus.ack), 32'(vecs[v].exp_ack));
      check("vec_grant_id", 32'(bus.grant_id), 32'(vecs[v].exp_gid));
      bus.req = '0;
      tick();
      check("vec_tx_wr_en", 32'(bus.tx_wr_en), 32'd1);
      check("vec_active", 32'(bus.active), 32'd1);
      wait_idle("vec_done");
      check("vec_active_after", 32'(bus.active), 32'd0);
    end

    // Reset in WAIT_DONE, with a short-lived request and a held one pending.
    busy_len = 40;
    wait_idle("rst_pre_idle");
    bus.req      = 4'b0100;
    bus.req_data = 32'h00E70000;
    sb_q.push_back(8'hE7);
    tick();
    check("rst_first_ack", 32'(bus.ack), 32'h4);
    bus.req = '0;
    hi_cnt = 0;
    while (!bus.tx_busy && hi_cnt < 20) begin
      tick();
      hi_cnt++;
    end
    check("rst_busy_seen", 32'(bus.tx_busy), 32'd1);
    c3 = ack_cnt[3];
    bus.req      = 4'b1000;
    bus.req_data = 32'h99000000;
    repeat (3) tick();
    bus.req      = 4'b0010;
    bus.req_data = 32'h0000F100;
    repeat (2) tick();
    check("rst_still_active", 32'(bus.active), 32'd1);
    sb_q.push_back(8'hF1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    check("ack_in_reset", 32'(bus.ack), 32'd0);
    rst_n = 1'b1;
    tick();
    check("no_grant_edge1", 32'(bus.ack), 32'd0);
    tick();
    check("grant_edge2_ack", 32'(bus.ack), 32'h2);
    check("grant_edge2_gid", 32'(bus.grant_id), 32'd1);
    bus.req = '0;
    wait_idle("rst_done");
    check("dropped_req_no_ack", 32'(ack_cnt[3]), 32'(c3));

    // Rotation with all requesters held.
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();
    busy_len = 3;
    for (int i = 0; i < NREQ; i++) base[i] = ack_cnt[i];
    bus.req      = 4'b1111;
    bus.req_data = 32'h13121110;
    sb_q.push_back(8'h10);
    sb_q.push_back(8'h11);
    sb_q.push_back(8'h12);
    sb_q.push_back(8'h13);
    sb_q.push_back(8'h10);
    n_ack = 0;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (bus.ack != '0) n_ack++;
      if (n_ack == 5) begin
        bus.req = '0;
        break;
      end
    end
    check("rot_acks", 32'(n_ack), 32'd5);
    wait_idle("rot_done");
    check("rot_cnt0", 32'(ack_cnt[0] - base[0]), 32'd2);
    check("rot_cnt1", 32'(ack_cnt[1] - base[1]), 32'd1);
    check("rot_cnt2", 32'(ack_cnt[2] - base[2]), 32'd1);
    check("rot_cnt3", 32'(ack_cnt[3] - base[3]), 32'd1);

    // tx_busy already high in IDLE holds off the grant.
    busy_force   = 1'b1;
    bus.req      = 4'b0001;
    bus.req_data = 32'h0000005A;
    sb_q.push_back(8'h5A);
    hi_cnt = 0;
    repeat (10) begin
      tick();
      if (bus.ack != '0) hi_cnt++;
    end
    check("busy_holdoff_acks", 32'(hi_cnt), 32'd0);
    busy_force = 1'b0;
    tick();
    check("busy_release_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    tick();
    check("busy_release_wr", 32'(bus.tx_wr_en), 32'd1);
    wait_idle("busy_done");

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    check("ack_eq_wr", 32'(ack_total), 32'(wr_total));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NREQ, default 4, SHALL set the number of byte requesters (legal range 2..8).
REQ-002 Parameter CLKS_PER_BIT, default 16, SHALL set the clk cycles per tx_enb pulse (minimum 2).
REQ-003 clk  input  1  SHALL be the single clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req  input  NREQ  SHALL carry level requests; bit i high means requester i holds a valid byte.
REQ-006 req_data  input  8*NREQ  SHALL carry requester i's byte in bits [8i+7:8i].
REQ-007 ack  output  NREQ  SHALL be a one-cycle pulse on the bit of the requester whose byte was taken.
REQ-008 tx_wr_en  output  1  SHALL drive the transmitter write strobe.
REQ-009 tx_data  output  8  SHALL drive the transmitter data input.
REQ-010 tx_enb  output  1  SHALL drive the transmitter bit-rate enable.
REQ-011 tx_busy  input  1  SHALL be the transmitter busy flag.
REQ-012 grant_id  output  3  SHALL hold the index of the last granted requester.
REQ-013 active  output  1  SHALL be high whenever the FSM is not in IDLE.

Function
REQ-014 The baud counter SHALL free-run 0..CLKS_PER_BIT-1, wrapping to 0; tx_enb SHALL be high for exactly the one cycle the counter equals CLKS_PER_BIT-1.
REQ-015 The FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY and WAIT_DONE.
REQ-016 In IDLE with req != 0, the FSM SHALL select a winner by round-robin, searching from grant_id+1 modulo NREQ upward, and latch the winner's byte into tx_data and its index into grant_id.
REQ-017 The IDLE-to-LAUNCH transition SHALL assert ack[winner] on that same clock edge for exactly one cycle.
REQ-018 LAUNCH SHALL assert tx_wr_en for exactly one cycle and then go to WAIT_BUSY.
REQ-019 In WAIT_BUSY, tx_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-020 In WAIT_DONE, tx_busy=0 SHALL move the FSM to IDLE.
REQ-021 Total latency SHALL be fixed: ack one cycle after req is sampled in IDLE, and tx_wr_en one cycle after ack.
REQ-022 tx_data SHALL stay stable from LAUNCH until the next grant.
REQ-023 Requests arriving outside IDLE SHALL be held off with no ack; no byte SHALL be lost or duplicated when req stays high.
REQ-024 When all req bits are high, grants SHALL rotate 0,1,2,3,0,... with no requester granted twice before every other requester is granted once.
REQ-025 A req that drops before being sampled in IDLE SHALL receive no ack.
REQ-026 If tx_busy is already high in IDLE, the FSM SHALL NOT grant until tx_busy is low.
REQ-027 ack SHALL be one-hot or zero in every cycle.

Reset
REQ-028 rst_n low SHALL immediately set the following, regardless of clk:
- FSM to IDLE
- baud counter to 0
- tx_enb, tx_wr_en, ack and active to 0
- tx_data to 8'h00
- grant_id to NREQ-1, so the first grant searches from requester 0
REQ-029 Reset asserted mid-transfer SHALL abandon the byte with no ack replay.
REQ-030 After rst_n rises, the first grant SHALL occur no earlier than the second rising clk edge.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the default NREQ and CLKS_PER_BIT values, and the byte width constant (8).
REQ-032 The baud-tick generator SHALL be one sub-module, uart_baud_tick, with CLKS_PER_BIT as its parameter and tx_enb as its output.
REQ-033 The round-robin search SHALL be combinational logic inside uart_tx_arbiter, with registered outputs only.

Verification
REQ-034 Reset release, CLKS_PER_BIT=16, no req -> tx_enb pulses every 16 cycles; ack, tx_wr_en and active stay 0.
REQ-035 req=4'b0100 with byte 8'hA5, transmitter model asserting busy for 40 cycles -> ack=4'b0100 once, tx_wr_en one cycle later with tx_data=8'hA5, grant_id=2, active low after busy falls.
REQ-036 req=4'b1111 held, bytes 8'h10/8'h11/8'h12/8'h13 -> tx_data order 8'h10, 8'h11, 8'h12, 8'h13, 8'h10, with exactly one ack per transfer.
REQ-037 req=4'b1001 held after a requester-0 grant -> next grant goes to requester 3, then requester 0.
REQ-038 rst_n pulsed low during WAIT_DONE -> all outputs zero immediately, grant_id=NREQ-1, no ack after release until req is resampled.
REQ-039 tx_busy forced high in IDLE with req=4'b0001 -> no ack until tx_busy is low, then ack=4'b0001 on the following edge.
